// File: rtl/cmp_seq_if.sv
// cmp_seq_if: start/busy/done handshake and operand/result bundle for cmp_seq.
//   master : sequencer side. It drives start, signed_mode, x and y, and
//            observes busy, done, eq, lt and gt.
//   slave  : comparator side. It is the mirror image of master.
//   WIDTH  : operand width. It must match the WIDTH of the attached cmp_seq.
interface cmp_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, signed_mode, x, y,
    input  busy, done, eq, lt, gt
  );

  modport slave (
    input  start, signed_mode, x, y,
    output busy, done, eq, lt, gt
  );
endinterface

// File: rtl/cmp_seq.sv
// cmp_seq: sequential magnitude comparator for WIDTH-bit operands, signed or unsigned.
//   The compare walks CHUNK bits per cycle, starting with the MSB chunk.
//   With EARLY_EXIT=1 it may stop on the first differing chunk.
// Ports:
//   clk   : rising-edge clock.
//   rst_n : asynchronous active-low reset.
//   bus   : cmp_seq_if.slave.
//           - start latches x, y and signed_mode.
//           - busy is high while the compare runs.
//           - done is a one-cycle pulse.
//           - eq/lt/gt are one-hot, registered, and held between completions.
module cmp_seq #(
  parameter int WIDTH      = 8,
  parameter int CHUNK      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  cmp_seq_if.slave  bus
);
  localparam int CH_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCH     = WIDTH / CH_SAFE;
  localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  generate
    if ((CHUNK < 1) || ((WIDTH % CH_SAFE) != 0)) begin : g_bad_width
      $error("cmp_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_x, r_y;
  logic             r_sgn;
  logic [IDX_W-1:0] r_idx;
  logic             r_dlt, r_dgt;   // sticky first-difference decision
  logic             r_eq, r_lt, r_gt;

  logic [WIDTH-1:0] w_xf, w_yf;
  logic [CHUNK-1:0] w_cx, w_cy;
  logic             w_clt, w_cgt;
  logic             w_load, w_fin;
  logic             w_dlt_n, w_dgt_n;

  // Flipping the sign bit maps two's complement onto an order-preserving
  // unsigned range, so a plain unsigned chunk compare works for both modes.
  assign w_xf = r_sgn ? (r_x ^ MSB_MASK) : r_x;
  assign w_yf = r_sgn ? (r_y ^ MSB_MASK) : r_y;

  // idx 0 selects the MSB chunk.
  assign w_cx  = CHUNK'(w_xf >> (CHUNK * (NCH - 1 - int'(r_idx))));
  assign w_cy  = CHUNK'(w_yf >> (CHUNK * (NCH - 1 - int'(r_idx))));
  assign w_clt = (w_cx < w_cy);
  assign w_cgt = (w_cx > w_cy);

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_fin   = 1'b0;
    w_dlt_n = r_dlt;
    w_dgt_n = r_dgt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end
      end
      S_RUN: begin
        // Only the first differing chunk may set the decision.
        if (!r_dlt && !r_dgt) begin
          w_dlt_n = w_clt;
          w_dgt_n = w_cgt;
        end
        if (((EARLY_EXIT != 0) && (w_clt || w_cgt)) ||
            (r_idx == IDX_W'(NCH - 1))) begin
          w_next = S_DONE;
          w_fin  = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_sgn   <= 1'b0;
      r_idx   <= '0;
      r_dlt   <= 1'b0;
      r_dgt   <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_x   <= bus.x;
        r_y   <= bus.y;
        r_sgn <= bus.signed_mode;
        r_idx <= '0;
        r_dlt <= 1'b0;
        r_dgt <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_idx <= r_idx + 1'b1;
        r_dlt <= w_dlt_n;
        r_dgt <= w_dgt_n;
      end
      if (w_fin) begin
        r_eq <= !w_dlt_n && !w_dgt_n;
        r_lt <= w_dlt_n;
        r_gt <= w_dgt_n;
      end
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.eq   = r_eq;
  assign bus.lt   = r_lt;
  assign bus.gt   = r_gt;
endmodule
